// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding and hazard detection for the decode stage of the 5-stage pipeline.
// Also tracks in-flight MDU destinations and counts stalled cycles.
module forwarding_hazard_unit #(
    parameter int DATA_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dec_valid,
    input  logic [REG_ADDR_WIDTH-1:0]  dec_rs_addr,
    input  logic [DATA_WIDTH-1:0]      dec_rs_data,
    input  logic [REG_ADDR_WIDTH-1:0]  dec_rt_addr,
    input  logic [DATA_WIDTH-1:0]      dec_rt_data,
    input  logic                       exec_wb,
    input  logic                       exec_uses_alu,
    input  logic [REG_ADDR_WIDTH-1:0]  exec_rd_addr,
    input  logic [DATA_WIDTH-1:0]      exec_data,
    input  logic                       mem_wb,
    input  logic [REG_ADDR_WIDTH-1:0]  mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]      mem_data,
    input  logic                       mem_data_valid,
    input  logic                       wb_wb,
    input  logic [REG_ADDR_WIDTH-1:0]  wb_rd_addr,
    input  logic [DATA_WIDTH-1:0]      wb_data,
    input  logic                       mdu_issue,
    input  logic [REG_ADDR_WIDTH-1:0]  mdu_rd_addr,
    input  logic                       mdu_done,
    input  logic [REG_ADDR_WIDTH-1:0]  mdu_done_addr,
    input  logic [DATA_WIDTH-1:0]      mdu_done_data,
    output logic [DATA_WIDTH-1:0]      fwd_rs_data,
    output logic [DATA_WIDTH-1:0]      fwd_rt_data,
    output logic                       stall,
    output logic [1:0]                 stall_reason,
    output logic                       mdu_busy,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

    logic [NUM_REGS-1:0]       scoreboard;
    logic [NUM_REGS-1:0]       scoreboard_next;
    logic [REG_ADDR_WIDTH-1:0] src [2];
    logic [DATA_WIDTH-1:0]     rf [2];
    logic [DATA_WIDTH-1:0]     fwd [2];
    logic [1:0]                nz, ex_hit, mem_hit, mdu_hit, wb_hit;
    logic [1:0]                load_use, cache_miss, mdu_pend;
    logic [1:0]                reason_next;

    // Index 0 = rs, index 1 = rt; both sources follow the identical rule.
    always_comb begin
        src[0] = dec_rs_addr;
        src[1] = dec_rt_addr;
        rf[0]  = dec_rs_data;
        rf[1]  = dec_rt_data;
        nz = '0; ex_hit = '0; mem_hit = '0; mdu_hit = '0; wb_hit = '0;
        load_use = '0; cache_miss = '0; mdu_pend = '0;
        fwd[0] = dec_rs_data;
        fwd[1] = dec_rt_data;
        for (int i = 0; i < 2; i++) begin
            nz[i]      = (src[i] != '0);
            ex_hit[i]  = nz[i] & exec_wb & (exec_rd_addr == src[i]);
            mem_hit[i] = nz[i] & mem_wb & (mem_rd_addr == src[i]);
            mdu_hit[i] = nz[i] & mdu_done & (mdu_done_addr == src[i]);
            wb_hit[i]  = nz[i] & wb_wb & (wb_rd_addr == src[i]);

            if (ex_hit[i] && exec_uses_alu) fwd[i] = exec_data;
            else if (mem_hit[i])            fwd[i] = mem_data;
            else if (mdu_hit[i])            fwd[i] = mdu_done_data;
            else if (wb_hit[i])             fwd[i] = wb_data;
            else                            fwd[i] = rf[i];

            // A same-cycle MDU completion is bypassed, so it never holds decode.
            load_use[i]   = dec_valid & ex_hit[i] & ~exec_uses_alu;
            cache_miss[i] = dec_valid & ~ex_hit[i] & mem_hit[i] & ~mem_data_valid;
            mdu_pend[i]   = dec_valid & nz[i] & scoreboard[src[i]]
                          & ~ex_hit[i] & ~mem_hit[i] & ~mdu_hit[i];
        end
    end

    assign fwd_rs_data = fwd[0];
    assign fwd_rt_data = fwd[1];
    assign stall = ~rst & ((|load_use) | (|cache_miss) | (|mdu_pend));

    always_comb begin
        reason_next = 2'd0;
        if (|load_use)        reason_next = 2'd1;
        else if (|cache_miss) reason_next = 2'd2;
        else if (|mdu_pend)   reason_next = 2'd3;
    end

    // Set is applied after clear so an issue to a just-completed register wins.
    always_comb begin
        scoreboard_next = scoreboard;
        if (mdu_done) scoreboard_next[mdu_done_addr] = 1'b0;
        if (mdu_issue && mdu_rd_addr != '0) scoreboard_next[mdu_rd_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scoreboard   <= '0;
            mdu_busy     <= 1'b0;
            stall_reason <= 2'd0;
            stall_cycles <= '0;
        end else begin
            scoreboard   <= scoreboard_next;
            mdu_busy     <= |scoreboard_next;
            stall_reason <= reason_next;
            if (stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + STALL_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Self-checking bench for forwarding_hazard_unit: a cycle model pushes expected outputs
// to queues as stimulus is applied; they are popped and compared when the DUT responds.
module tb_forwarding_hazard_unit;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          dec_valid;
    logic [AW-1:0] dec_rs_addr, dec_rt_addr;
    logic [DW-1:0] dec_rs_data, dec_rt_data;
    logic          exec_wb, exec_uses_alu;
    logic [AW-1:0] exec_rd_addr;
    logic [DW-1:0] exec_data;
    logic          mem_wb, mem_data_valid;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_data;
    logic          wb_wb;
    logic [AW-1:0] wb_rd_addr;
    logic [DW-1:0] wb_data;
    logic          mdu_issue, mdu_done;
    logic [AW-1:0] mdu_rd_addr, mdu_done_addr;
    logic [DW-1:0] mdu_done_data;
    logic [DW-1:0] fwd_rs_data, fwd_rt_data;
    logic          stall;
    logic [1:0]    stall_reason;
    logic          mdu_busy;
    logic [CW-1:0] stall_cycles;

    // clock / reset
    always #5 clk = ~clk;

    forwarding_hazard_unit #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .STALL_CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_rs_addr(dec_rs_addr), .dec_rs_data(dec_rs_data),
        .dec_rt_addr(dec_rt_addr), .dec_rt_data(dec_rt_data),
        .exec_wb(exec_wb), .exec_uses_alu(exec_uses_alu),
        .exec_rd_addr(exec_rd_addr), .exec_data(exec_data),
        .mem_wb(mem_wb), .mem_rd_addr(mem_rd_addr), .mem_data(mem_data),
        .mem_data_valid(mem_data_valid),
        .wb_wb(wb_wb), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .mdu_issue(mdu_issue), .mdu_rd_addr(mdu_rd_addr),
        .mdu_done(mdu_done), .mdu_done_addr(mdu_done_addr), .mdu_done_data(mdu_done_data),
        .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data), .stall(stall),
        .stall_reason(stall_reason), .mdu_busy(mdu_busy), .stall_cycles(stall_cycles)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard: reference state and expected-value queues
    logic [2**AW-1:0] m_sb     = '0;
    logic [1:0]       m_reason = '0;
    logic             m_busy   = 1'b0;
    logic [CW-1:0]    m_cnt    = '0;
    logic [2*DW:0]    exp_comb_q[$];
    logic [CW+2:0]    exp_reg_q[$];

    function automatic logic [DW-1:0] model_fwd(input logic [AW-1:0] a, input logic [DW-1:0] rf);
        if (a == '0) return rf;
        if (exec_wb && exec_uses_alu && exec_rd_addr == a) return exec_data;
        if (mem_wb && mem_rd_addr == a) return mem_data;
        if (mdu_done && mdu_done_addr == a) return mdu_done_data;
        if (wb_wb && wb_rd_addr == a) return wb_data;
        return rf;
    endfunction

    function automatic logic [1:0] model_haz(input logic [AW-1:0] a);
        logic ex_m, mem_m;
        if (rst || !dec_valid || a == '0) return 2'd0;
        ex_m  = exec_wb && exec_rd_addr == a;
        mem_m = mem_wb && mem_rd_addr == a;
        if (ex_m && !exec_uses_alu) return 2'd1;
        if (!ex_m && mem_m && !mem_data_valid) return 2'd2;
        if (m_sb[a] && !ex_m && !mem_m && !(mdu_done && mdu_done_addr == a)) return 2'd3;
        return 2'd0;
    endfunction

    // One clock: inputs are already set by the caller (just after a rising edge).
    task automatic cycle();
        logic [1:0]    hs, ht, r;
        logic          st;
        logic [2*DW:0] ec;
        logic [CW+2:0] er;
        hs = model_haz(dec_rs_addr);
        ht = model_haz(dec_rt_addr);
        if (hs == 2'd1 || ht == 2'd1)      r = 2'd1;
        else if (hs == 2'd2 || ht == 2'd2) r = 2'd2;
        else if (hs == 2'd3 || ht == 2'd3) r = 2'd3;
        else                               r = 2'd0;
        st = (r != 2'd0);
        exp_comb_q.push_back({model_fwd(dec_rs_addr, dec_rs_data),
                              model_fwd(dec_rt_addr, dec_rt_data), st});
        if (rst) begin
            m_sb = '0; m_reason = '0; m_busy = 1'b0; m_cnt = '0;
        end else begin
            if (mdu_done) m_sb[mdu_done_addr] = 1'b0;
            if (mdu_issue && mdu_rd_addr != '0) m_sb[mdu_rd_addr] = 1'b1;
            m_reason = r;
            m_busy   = |m_sb;
            if (st && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
        end
        exp_reg_q.push_back({m_reason, m_busy, m_cnt});
        @(negedge clk);
        ec = exp_comb_q.pop_front();
        check("fwd_rs", 64'(fwd_rs_data), 64'(ec[2*DW:DW+1]));
        check("fwd_rt", 64'(fwd_rt_data), 64'(ec[DW:1]));
        check("stall",  64'(stall),       64'(ec[0]));
        @(posedge clk);
        #1;
        er = exp_reg_q.pop_front();
        check("stall_reason", 64'(stall_reason), 64'(er[CW+2:CW+1]));
        check("mdu_busy",     64'(mdu_busy),     64'(er[CW]));
        check("stall_cycles", 64'(stall_cycles), 64'(er[CW-1:0]));
    endtask

    // driver tasks
    task automatic idle();
        rst = 1'b0; dec_valid = 1'b0;
        dec_rs_addr = '0; dec_rt_addr = '0; dec_rs_data = '0; dec_rt_data = '0;
        exec_wb = 1'b0; exec_uses_alu = 1'b1; exec_rd_addr = '0; exec_data = '0;
        mem_wb = 1'b0; mem_rd_addr = '0; mem_data = '0; mem_data_valid = 1'b1;
        wb_wb = 1'b0; wb_rd_addr = '0; wb_data = '0;
        mdu_issue = 1'b0; mdu_rd_addr = '0; mdu_done = 1'b0; mdu_done_addr = '0;
        mdu_done_data = '0;
    endtask

    task automatic do_reset(input int n);
        idle();
        rst = 1'b1;
        repeat (n) cycle();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        #1;
        // reset, then idle forwarding
        do_reset(2);
        check("rst_stall_cycles", 64'(stall_cycles), 64'd0);
        check("rst_mdu_busy", 64'(mdu_busy), 64'd0);
        dec_valid = 1'b1; dec_rs_addr = 5'd3; dec_rs_data = 32'h11;
        dec_rt_addr = 5'd2; dec_rt_data = 32'h22;
        cycle();
        check("idle_fwd_rs", 64'(fwd_rs_data), 64'h11);

        // forwarding priority
        exec_wb = 1'b1; exec_uses_alu = 1'b1; exec_rd_addr = 5'd4; exec_data = 32'hA;
        mem_wb = 1'b1; mem_rd_addr = 5'd4; mem_data = 32'hB;
        wb_wb = 1'b1; wb_rd_addr = 5'd4; wb_data = 32'hC;
        dec_rs_addr = 5'd4; dec_rs_data = 32'h44;
        cycle();
        check("prio_ex", 64'(fwd_rs_data), 64'hA);
        exec_wb = 1'b0;
        cycle();
        check("prio_mem", 64'(fwd_rs_data), 64'hB);
        mem_wb = 1'b0; dec_rt_addr = 5'd4;
        cycle();
        check("prio_wb", 64'(fwd_rt_data), 64'hC);
        exec_wb = 1'b1; exec_uses_alu = 1'b0; exec_rd_addr = '0;
        mem_wb = 1'b1; mem_rd_addr = '0; mem_data_valid = 1'b0;
        wb_rd_addr = '0; dec_rs_addr = '0; dec_rs_data = 32'h55;
        dec_rt_addr = '0; dec_rt_data = 32'h66;
        cycle();
        check("r0_fwd", 64'(fwd_rs_data), 64'h55);
        check("r0_stall", 64'(stall), 64'd0);

        // load-use
        idle();
        exec_wb = 1'b1; exec_uses_alu = 1'b0; exec_rd_addr = 5'd5;
        dec_valid = 1'b1; dec_rt_addr = 5'd5;
        cycle();
        check("lu_reason", 64'(stall_reason), 64'd1);
        check("lu_cycles", 64'(stall_cycles), 64'd1);
        dec_valid = 1'b0;
        cycle();

        // cache miss held three cycles
        do_reset(1);
        mem_wb = 1'b1; mem_rd_addr = 5'd6; mem_data_valid = 1'b0;
        dec_valid = 1'b1; dec_rs_addr = 5'd6;
        repeat (3) cycle();
        check("miss_cycles", 64'(stall_cycles), 64'd3);
        check("miss_reason", 64'(stall_reason), 64'd2);
        mem_data_valid = 1'b1; mem_data = 32'h77;
        cycle();
        check("miss_fwd", 64'(fwd_rs_data), 64'h77);

        // MDU scoreboard
        idle();
        mdu_issue = 1'b1; mdu_rd_addr = 5'd8;
        cycle();
        check("mdu_busy_set", 64'(mdu_busy), 64'd1);
        mdu_issue = 1'b0; dec_valid = 1'b1; dec_rs_addr = 5'd8;
        cycle();
        check("mdu_reason", 64'(stall_reason), 64'd3);
        mdu_done = 1'b1; mdu_done_addr = 5'd8; mdu_done_data = 32'h99;
        cycle();
        check("mdu_busy_clr", 64'(mdu_busy), 64'd0);
        idle();
        mdu_issue = 1'b1; mdu_rd_addr = 5'd8;
        cycle();
        mdu_done = 1'b1; mdu_done_addr = 5'd8;
        cycle();
        check("mdu_set_wins", 64'(mdu_busy), 64'd1);
        idle();
        dec_valid = 1'b1; dec_rs_addr = 5'd8;
        cycle();
        mdu_done = 1'b1; mdu_done_addr = 5'd8; mdu_done_data = 32'h1234;
        cycle();
        mdu_done = 1'b1; mdu_done_addr = 5'd8;
        dec_valid = 1'b0;
        cycle();

        // randomized traffic over a small register window to force collisions
        for (int k = 0; k < 300; k++) begin
            dec_valid     = 1'($urandom_range(0, 1));
            dec_rs_addr   = AW'($urandom_range(0, 7));
            dec_rt_addr   = AW'($urandom_range(0, 7));
            dec_rs_data   = $urandom;
            dec_rt_data   = $urandom;
            exec_wb       = 1'($urandom_range(0, 1));
            exec_uses_alu = ($urandom_range(0, 3) != 0);
            exec_rd_addr  = AW'($urandom_range(0, 7));
            exec_data     = $urandom;
            mem_wb        = 1'($urandom_range(0, 1));
            mem_rd_addr   = AW'($urandom_range(0, 7));
            mem_data      = $urandom;
            mem_data_valid = ($urandom_range(0, 3) != 0);
            wb_wb         = 1'($urandom_range(0, 1));
            wb_rd_addr    = AW'($urandom_range(0, 7));
            wb_data       = $urandom;
            mdu_issue     = ($urandom_range(0, 3) == 0);
            mdu_rd_addr   = AW'($urandom_range(0, 7));
            mdu_done      = ($urandom_range(0, 2) == 0);
            mdu_done_addr = AW'($urandom_range(0, 7));
            mdu_done_data = $urandom;
            cycle();
        end

        // saturation, then reset mid-stall
        do_reset(1);
        mdu_issue = 1'b1; mdu_rd_addr = 5'd9;
        cycle();
        mdu_issue = 1'b0;
        exec_wb = 1'b1; exec_uses_alu = 1'b0; exec_rd_addr = 5'd5;
        dec_valid = 1'b1; dec_rs_addr = 5'd5;
        repeat (20) cycle();
        check("sat_cycles", 64'(stall_cycles), 64'd15);
        cycle();
        check("sat_hold", 64'(stall_cycles), 64'd15);
        rst = 1'b1;
        cycle();
        check("rst_mid_cycles", 64'(stall_cycles), 64'd0);
        check("rst_mid_busy", 64'(mdu_busy), 64'd0);
        rst = 1'b0;
        dec_valid = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
